// File: rtl/gray_conv_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gray_conv_arbiter                                          |
// | Description : Round-robin arbiter sharing one binary-to-Gray converter   |
// |               among NREQ requesters, with a valid/ready output register. |
// |               Define GRAY_ARB_CNT_EN to add per-requester grant counters.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module gray_conv_arbiter #(
    parameter int n    = 3,
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*n-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [n-1:0]        out_gray,
    output logic [n-1:0]        out_bin,
    output logic [IW-1:0]       out_id,
    output logic                busy
`ifdef GRAY_ARB_CNT_EN
    ,
    output logic [NREQ*8-1:0]   grant_cnt
`endif
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [IW-1:0]   r_ptr;
    logic [n-1:0]    r_bin;
    logic [n-1:0]    r_gray;
    logic [IW-1:0]   r_id;

    logic            w_can_accept;
    logic            w_any;
    logic            w_xfer;
    logic [IW-1:0]   w_win;
    logic [IW-1:0]   w_idx;
    logic [NREQ-1:0] w_grant;
    logic [n-1:0]    w_win_data;

    assign w_can_accept = (r_state == S_EMPTY) | out_ready;

    // Scan from the farthest slot back to ptr so the slot nearest ptr wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = r_ptr + IW'(k);
            if (req_valid[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (rst_n && w_can_accept && w_any) begin
            w_grant[w_win] = 1'b1;
        end
    end

    assign req_ready  = w_grant;
    assign w_xfer     = |w_grant;
    assign w_win_data = req_data[int'(w_win)*n +: n];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_xfer) begin
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (w_xfer) begin
                    w_state_nxt = S_FULL;
                end else if (out_ready) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (r_state == S_FULL);
        busy      = (r_state == S_FULL);
    end

    // Data registers only load on a transfer; a plain consume leaves them holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_id   <= '0;
            r_ptr  <= '0;
        end else if (w_xfer) begin
            r_bin  <= w_win_data;
            r_gray <= w_win_data ^ (w_win_data >> 1);
            r_id   <= w_win;
            r_ptr  <= w_win + IW'(1);
        end
    end

    assign out_bin  = r_bin;
    assign out_gray = r_gray;
    assign out_id   = r_id;

`ifdef GRAY_ARB_CNT_EN
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_cnt
            logic [7:0] r_cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_grant[gi] && (r_cnt != 8'hFF)) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
            assign grant_cnt[gi*8 +: 8] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_gray_conv_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_gray_conv_arbiter                                       |
// | Description : Self-checking bench for gray_conv_arbiter (n=3, NREQ=4)    |
// |               against a reference model; honours GRAY_ARB_CNT_EN.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_gray_conv_arbiter;

    localparam int N    = 3;
    localparam int NREQ = 4;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*N-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      out_gray;
    logic [N-1:0]      out_bin;
    logic [IW-1:0]     out_id;
    logic              busy;
`ifdef GRAY_ARB_CNT_EN
    logic [NREQ*8-1:0] grant_cnt;
`endif

    always #5 clk = ~clk;

    gray_conv_arbiter #(.n(N), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_bin   (out_bin),
        .out_id    (out_id),
        .busy      (busy)
`ifdef GRAY_ARB_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit m_valid;
    int m_bin, m_id, m_ptr;
    int m_cnt [NREQ];
    int gtab  [1 << N];

    // Reflected Gray code table built by mirroring, independent of the xor formula.
    task automatic build_gtab();
        gtab[0] = 0;
        for (int m = 0; m < N; m++) begin
            int sz = 1 << m;
            for (int k = 0; k < sz; k++) gtab[sz + k] = gtab[sz - 1 - k] | sz;
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_bin = 0; m_id = 0; m_ptr = 0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    endtask

    function automatic int exp_grant();
        if (!rst_n) return -1;
        if (m_valid && !out_ready) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int i = (m_ptr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready();
        int g = exp_grant();
        return (g < 0) ? '0 : NREQ'(1 << g);
    endfunction

    // Advance one clock, updating the model; returns at the following negedge.
    task automatic tick();
        int g = exp_grant();
        int d = (g >= 0) ? int'((req_data >> (g * N)) & 12'h7) : 0;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (g >= 0) begin
            m_valid = 1; m_bin = d; m_id = g; m_ptr = (g + 1) % NREQ;
            if (m_cnt[g] < 255) m_cnt[g]++;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 4'hF; out_ready = 1'b1; req_data = 12'($urandom);
        model_reset();
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp += 4;
            if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
            if (req_ready !== 4'h0) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
            if (out_gray !== 3'b000) begin n_bad++; $display("FAIL reset_gray: got %b want 000", out_gray); end
            if (out_id !== 2'd0) begin n_bad++; $display("FAIL reset_id: got %0d want 0", out_id); end
            tick();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req_valid = 4'b0100; out_ready = 1'b1;
        req_data = 12'($urandom);
        req_data[8:6] = 3'b101;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        tick();
        n_cmp += 4;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", out_valid); end
        if (out_gray !== 3'b111) begin n_bad++; $display("FAIL single_gray: got %b want 111", out_gray); end
        if (out_bin !== 3'b101) begin n_bad++; $display("FAIL single_bin: got %b want 101", out_bin); end
        if (out_id !== 2'd2) begin n_bad++; $display("FAIL single_id: got %0d want 2", out_id); end
    endtask

    task automatic test_round_robin();
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        rst_n = 1'b0; req_valid = 4'hF; out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req_data = 12'($urandom);
            #1;
            tick();
            n_cmp += 2;
            if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rr_valid[%0d]: got %b want 1", k, out_valid); end
            if (int'(out_id) != exp_seq[k]) begin n_bad++; $display("FAIL rr_id[%0d]: got %0d want %0d", k, out_id, exp_seq[k]); end
        end
    endtask

    task automatic test_stall();
        logic [N-1:0]  sv_gray, sv_bin;
        logic [IW-1:0] sv_id;
        sv_gray = out_gray; sv_bin = out_bin; sv_id = out_id;
        out_ready = 1'b0; req_valid = 4'hF;
        for (int c = 0; c < 3; c++) begin
            req_data = 12'($urandom);
            #1;
            n_cmp++;
            if (req_ready !== 4'h0) begin n_bad++; $display("FAIL stall_ready[%0d]: got %b want 0000", c, req_ready); end
            tick();
            n_cmp += 4;
            if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d]: got %b want 1", c, out_valid); end
            if (out_gray !== sv_gray) begin n_bad++; $display("FAIL stall_gray[%0d]: got %b want %b", c, out_gray, sv_gray); end
            if (out_bin !== sv_bin) begin n_bad++; $display("FAIL stall_bin[%0d]: got %b want %b", c, out_bin, sv_bin); end
            if (out_id !== sv_id) begin n_bad++; $display("FAIL stall_id[%0d]: got %0d want %0d", c, out_id, sv_id); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== NREQ'(1 << m_ptr)) begin
            n_bad++; $display("FAIL stall_release_ready: got %b want %b", req_ready, NREQ'(1 << m_ptr));
        end
        tick();
        n_cmp++;
        if (int'(out_id) != m_id) begin n_bad++; $display("FAIL stall_release_id: got %0d want %0d", out_id, m_id); end
    endtask

    task automatic test_gray_sequence();
        logic [N-1:0] exp_g [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
        req_valid = 4'b0001; out_ready = 1'b1;
        for (int b = 0; b < 8; b++) begin
            req_data = {9'($urandom), 3'(b)};
            #1;
            tick();
            n_cmp += 2;
            if (out_gray !== exp_g[b]) begin n_bad++; $display("FAIL seq_gray[%0d]: got %b want %b", b, out_gray, exp_g[b]); end
            if (int'(out_bin) != b) begin n_bad++; $display("FAIL seq_bin[%0d]: got %0d want %0d", b, out_bin, b); end
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] er;
        for (int c = 0; c < 300; c++) begin
            req_valid = NREQ'($urandom);
            req_data  = 12'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            er = exp_ready();
            n_cmp++;
            if (req_ready !== er) begin n_bad++; $display("FAIL rnd_ready[%0d]: got %b want %b", c, req_ready, er); end
            tick();
            n_cmp += 5;
            if (out_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", c, out_valid, m_valid); end
            if (busy !== m_valid) begin n_bad++; $display("FAIL rnd_busy[%0d]: got %b want %b", c, busy, m_valid); end
            if (int'(out_bin) != m_bin) begin n_bad++; $display("FAIL rnd_bin[%0d]: got %0d want %0d", c, out_bin, m_bin); end
            if (int'(out_gray) != gtab[m_bin]) begin n_bad++; $display("FAIL rnd_gray[%0d]: got %0d want %0d", c, out_gray, gtab[m_bin]); end
            if (int'(out_id) != m_id) begin n_bad++; $display("FAIL rnd_id[%0d]: got %0d want %0d", c, out_id, m_id); end
`ifdef GRAY_ARB_CNT_EN
            for (int i = 0; i < NREQ; i++) begin
                n_cmp++;
                if (int'(grant_cnt[i*8 +: 8]) != m_cnt[i]) begin
                    n_bad++; $display("FAIL rnd_cnt%0d[%0d]: got %0d want %0d", i, c, grant_cnt[i*8 +: 8], m_cnt[i]);
                end
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 4'hF; out_ready = 1'b1; req_data = 12'($urandom);
        #1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp += 4;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_async_valid: got %b want 0", out_valid); end
        if (out_gray !== 3'b000) begin n_bad++; $display("FAIL mid_async_gray: got %b want 000", out_gray); end
        if (out_id !== 2'd0) begin n_bad++; $display("FAIL mid_async_id: got %0d want 0", out_id); end
        if (req_ready !== 4'h0) begin n_bad++; $display("FAIL mid_async_ready: got %b want 0000", req_ready); end
        tick();
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_first_ready: got %b want 0001", req_ready); end
        tick();
        n_cmp++;
        if (out_id !== 2'd0) begin n_bad++; $display("FAIL mid_first_id: got %0d want 0", out_id); end
`ifdef GRAY_ARB_CNT_EN
        n_cmp++;
        if (grant_cnt !== 32'h0000_0001) begin n_bad++; $display("FAIL cnt_after_reset: got %h want 00000001", grant_cnt); end
        req_valid = 4'b0010;
        for (int c = 0; c < 300; c++) begin
            req_data = 12'($urandom);
            #1;
            tick();
        end
        n_cmp += 2;
        if (grant_cnt[15:8] !== 8'hFF) begin n_bad++; $display("FAIL cnt_sat: got %h want ff", grant_cnt[15:8]); end
        if (grant_cnt[7:0] !== 8'h01) begin n_bad++; $display("FAIL cnt_other: got %h want 01", grant_cnt[7:0]); end
`endif
    endtask

    initial begin
        build_gtab();
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_gray_sequence();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
